// File: rtl/spi_host_seq_if.sv
// Command, tx and rx stream signals between the CSR/FIFO layer and spi_host_seq.
// slave is the sequencer side; master is the producer/consumer side.
interface spi_host_seq_if #(
    parameter int LenW = 8
);
    logic            cmd_valid_i;
    logic            cmd_ready_o;
    logic [LenW-1:0] cmd_len_i;
    logic            cmd_keep_cs_i;
    logic            tx_valid_i;
    logic            tx_ready_o;
    logic [7:0]      tx_data_i;
    logic            rx_valid_o;
    logic            rx_ready_i;
    logic [7:0]      rx_data_o;

    modport slave (
        input  cmd_valid_i, cmd_len_i, cmd_keep_cs_i, tx_valid_i, tx_data_i, rx_ready_i,
        output cmd_ready_o, tx_ready_o, rx_valid_o, rx_data_o
    );

    modport master (
        output cmd_valid_i, cmd_len_i, cmd_keep_cs_i, tx_valid_i, tx_data_i, rx_ready_i,
        input  cmd_ready_o, tx_ready_o, rx_valid_o, rx_data_o
    );
endinterface

// File: rtl/spi_host_seq.sv
// SPI host transfer sequencer: runs cmd segments of tx/rx bytes on sck/csb/mosi/miso.
// Optional debug outputs are enabled by defining SPI_HOST_SEQ_DBG_EN.
module spi_host_seq #(
    parameter int ClkDivW = 16,
    parameter int LenW    = 8
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               cfg_cpol_i,
    input  logic               cfg_cpha_i,
    input  logic [ClkDivW-1:0] cfg_clkdiv_i,
    spi_host_seq_if.slave      bus,
    output logic               busy_o,
    output logic               sck_o,
    output logic               csb_o,
    output logic               mosi_o,
    input  logic               miso_i
`ifdef SPI_HOST_SEQ_DBG_EN
    ,
    output logic [7:0]         dbg_host_byte_o,
    output logic [3:0]         dbg_host_bit_o,
    output logic [31:0]        dbg_sck_pulses_o
`endif
);

    typedef enum logic [2:0] {
        IDLE,
        CS_SETUP,
        LOAD,
        SHIFT,
        CS_HOLD,
        CS_HOLD_KEEP
    } state_t;

    state_t r_state;
    state_t w_next;

    logic               r_cpol;
    logic               r_cpha;
    logic [ClkDivW-1:0] r_clkdiv;
    logic               r_keep;
    logic [LenW-1:0]    r_bytesLeft;
    logic [ClkDivW-1:0] r_hcnt;
    logic [4:0]         r_tog;
    logic [7:0]         r_txSh;
    logic [7:0]         r_rxSh;
    logic               r_sck;
    logic               r_mosi;
    logic               r_rxValid;
    logic [7:0]         r_rxData;

    logic w_cmdReady;
    logic w_cmdFire;
    logic w_txFire;
    logic w_halfDone;
    logic w_timed;
    logic w_toggle;
    logic w_leading;
    logic w_byteDone;

    assign w_cmdReady = ((r_state == IDLE) || (r_state == CS_HOLD_KEEP)) && !rst_i;
    assign w_cmdFire  = bus.cmd_valid_i && w_cmdReady;
    assign w_txFire   = (r_state == LOAD) && bus.tx_valid_i && !r_rxValid && !rst_i;
    assign w_halfDone = (r_hcnt == r_clkdiv);
    assign w_timed    = (r_state == CS_SETUP) || (r_state == SHIFT) || (r_state == CS_HOLD);
    // r_tog counts completed toggles; even r_tog means the next toggle is a leading edge
    assign w_toggle   = (r_state == SHIFT) && !r_tog[4] && w_halfDone;
    assign w_leading  = w_toggle && !r_tog[0];
    assign w_byteDone = (r_state == SHIFT) && (r_tog == 5'd16);

    assign bus.cmd_ready_o = w_cmdReady;
    assign bus.tx_ready_o  = w_txFire;
    assign bus.rx_valid_o  = r_rxValid;
    assign bus.rx_data_o   = r_rxData;
    assign busy_o          = (r_state != IDLE);
    assign csb_o           = (r_state == IDLE);
    assign sck_o           = r_sck;
    assign mosi_o          = r_mosi;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:         if (w_cmdFire) w_next = CS_SETUP;
            CS_SETUP:     if (w_halfDone) w_next = LOAD;
            LOAD:         if (w_txFire) w_next = SHIFT;
            SHIFT: begin
                if (w_byteDone) begin
                    if (r_bytesLeft != '0) begin
                        w_next = LOAD;
                    end else if (r_keep) begin
                        w_next = CS_HOLD_KEEP;
                    end else begin
                        w_next = CS_HOLD;
                    end
                end
            end
            CS_HOLD:      if (w_halfDone) w_next = IDLE;
            CS_HOLD_KEEP: if (w_cmdFire) w_next = LOAD;
            default:      w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cpol      <= 1'b0;
            r_cpha      <= 1'b0;
            r_clkdiv    <= '0;
            r_keep      <= 1'b0;
            r_bytesLeft <= '0;
            r_hcnt      <= '0;
            r_tog       <= '0;
            r_txSh      <= '0;
            r_rxSh      <= '0;
            r_sck       <= 1'b0;
            r_mosi      <= 1'b0;
            r_rxValid   <= 1'b0;
            r_rxData    <= '0;
        end else begin
            // Half-period timer restarts on every state change and every SCK toggle
            if (w_timed && (w_next == r_state) && !w_toggle) begin
                r_hcnt <= r_hcnt + ClkDivW'(1);
            end else begin
                r_hcnt <= '0;
            end

            if (r_state == IDLE) begin
                r_sck <= w_cmdFire ? cfg_cpol_i : r_cpol;
                if (w_cmdFire) begin
                    r_cpol   <= cfg_cpol_i;
                    r_cpha   <= cfg_cpha_i;
                    r_clkdiv <= cfg_clkdiv_i;
                end
            end

            if (w_cmdFire) begin
                r_bytesLeft <= bus.cmd_len_i;
                r_keep      <= bus.cmd_keep_cs_i;
            end

            if (w_txFire) begin
                r_txSh <= bus.tx_data_i;
                r_tog  <= '0;
                if (!r_cpha) begin
                    r_mosi <= bus.tx_data_i[7];
                end
            end

            // CPHA=0 samples on leading edges, CPHA=1 on trailing; mosi moves on the other edge
            if (w_toggle) begin
                r_sck <= ~r_sck;
                r_tog <= r_tog + 5'd1;
                if (w_leading) begin
                    if (r_cpha) begin
                        r_mosi <= r_txSh[7];
                        r_txSh <= {r_txSh[6:0], 1'b0};
                    end else begin
                        r_rxSh <= {r_rxSh[6:0], miso_i};
                    end
                end else begin
                    if (r_cpha) begin
                        r_rxSh <= {r_rxSh[6:0], miso_i};
                    end else if (r_tog != 5'd15) begin
                        r_mosi <= r_txSh[6];
                        r_txSh <= {r_txSh[6:0], 1'b0};
                    end
                end
            end

            if (w_byteDone) begin
                r_rxData  <= r_rxSh;
                r_rxValid <= 1'b1;
                if (r_bytesLeft != '0) begin
                    r_bytesLeft <= r_bytesLeft - LenW'(1);
                end
            end else if (r_rxValid && bus.rx_ready_i) begin
                r_rxValid <= 1'b0;
            end
        end
    end

`ifdef SPI_HOST_SEQ_DBG_EN
    logic [7:0]  r_dbgByte;
    logic [3:0]  r_dbgBit;
    logic [31:0] r_dbgPulses;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_dbgByte   <= '0;
            r_dbgBit    <= '0;
            r_dbgPulses <= '0;
        end else begin
            if (w_txFire) begin
                r_dbgByte <= bus.tx_data_i;
                r_dbgBit  <= 4'd7;
            end else if (w_toggle && !w_leading && (r_dbgBit != 4'd0)) begin
                r_dbgBit <= r_dbgBit - 4'd1;
            end
            if (w_leading) begin
                r_dbgPulses <= r_dbgPulses + 32'd1;
            end
        end
    end

    assign dbg_host_byte_o  = r_dbgByte;
    assign dbg_host_bit_o   = r_dbgBit;
    assign dbg_sck_pulses_o = r_dbgPulses;
`endif

endmodule

// File: tb/tb_spi_host_seq.sv
// Directed self-checking bench for spi_host_seq: modes, keep-cs chaining,
// rx backpressure, mid-byte reset and a long clkdiv=0 segment.
module tb_spi_host_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfgCpol;
    logic        cfgCpha;
    logic [15:0] cfgClkdiv;
    logic        busy;
    logic        sck;
    logic        csb;
    logic        mosi;
    logic        miso;
    logic        misoLoop;
    logic        misoConst;

    always #5 clk = ~clk;

    spi_host_seq_if #(.LenW(8)) ifc ();

`ifdef SPI_HOST_SEQ_DBG_EN
    logic [7:0]  dbgByte;
    logic [3:0]  dbgBit;
    logic [31:0] dbgPulses;
`endif

    spi_host_seq #(.ClkDivW(16), .LenW(8)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .cfg_cpol_i   (cfgCpol),
        .cfg_cpha_i   (cfgCpha),
        .cfg_clkdiv_i (cfgClkdiv),
        .bus          (ifc),
        .busy_o       (busy),
        .sck_o        (sck),
        .csb_o        (csb),
        .mosi_o       (mosi),
        .miso_i       (miso)
`ifdef SPI_HOST_SEQ_DBG_EN
        ,
        .dbg_host_byte_o  (dbgByte),
        .dbg_host_bit_o   (dbgBit),
        .dbg_sck_pulses_o (dbgPulses)
`endif
    );

    assign miso = misoLoop ? mosi : misoConst;

    // Tx source: bytes are queued up front and popped after each accepted load
    logic [7:0] txArr [0:511];
    int         txCount = 0;
    int         txIdx   = 0;
    logic       popPending = 1'b0;

    assign ifc.tx_valid_i = (txIdx < txCount);
    assign ifc.tx_data_i  = (txIdx < 512) ? txArr[txIdx] : 8'h00;

    always @(posedge clk) begin
        #1;
        if (popPending) txIdx++;
    end

    int         cycCnt = 0;
    int         pulseCnt = 0;
    int         csbLowCnt = 0;
    int         csbRiseCnt = 0;
    int         txPopCnt = 0;
    int         rxCnt = 0;
    int         pulseCyc [0:4095];
    logic [7:0] rxArr [0:511];
    logic       tbCpol = 1'b0;
    logic       prevSck = 1'b0;
    logic       prevCsb = 1'b1;

    always @(negedge clk) begin
        cycCnt++;
        popPending = 1'b0;
        if (!rst) begin
            if (!csb) csbLowCnt++;
            if (!prevCsb && csb) csbRiseCnt++;
            if (!csb && (prevSck == tbCpol) && (sck != tbCpol)) begin
                if (pulseCnt < 4096) pulseCyc[pulseCnt] = cycCnt;
                pulseCnt++;
            end
            if (ifc.tx_ready_o) begin
                txPopCnt++;
                popPending = 1'b1;
            end
            if (ifc.rx_valid_o && ifc.rx_ready_i) begin
                if (rxCnt < 512) rxArr[rxCnt] = ifc.rx_data_o;
                rxCnt++;
            end
        end
        prevSck = sck;
        prevCsb = csb;
    end

    int checkCount = 0;
    int passCount  = 0;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic pushTx(input logic [7:0] b);
        txArr[txCount] = b;
        txCount++;
    endtask

    // Issues one command, then scrambles cfg so late cfg changes would be visible
    task automatic applyStimulus(input logic cpol, input logic cpha, input logic [15:0] div,
                                 input logic [7:0] len, input logic keep);
        int n;
        n = 0;
        cfgCpol = cpol;
        cfgCpha = cpha;
        cfgClkdiv = div;
        ifc.cmd_len_i = len;
        ifc.cmd_keep_cs_i = keep;
        ifc.cmd_valid_i = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (!ifc.cmd_ready_o && n < 300);
        if (!ifc.cmd_ready_o) checkOutput("cmdAccept", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        ifc.cmd_valid_i = 1'b0;
        cfgCpol = ~cpol;
        cfgCpha = ~cpha;
        cfgClkdiv = 16'd7;
    endtask

    task automatic waitIdle(input string tag, input int budget);
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        checkOutput({tag, "_idle"}, {31'd0, busy}, 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #5000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int pulseBase, csbBase, riseBase, popBase, rxBase, n, rxErrs;

        rst = 1'b1;
        cfgCpol = 1'b0;
        cfgCpha = 1'b0;
        cfgClkdiv = 16'd1;
        misoLoop = 1'b1;
        misoConst = 1'b0;
        ifc.cmd_valid_i = 1'b0;
        ifc.cmd_len_i = 8'd0;
        ifc.cmd_keep_cs_i = 1'b0;
        ifc.rx_ready_i = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_csb", {31'd0, csb}, 32'd1);
        checkOutput("rst_sck", {31'd0, sck}, 32'd0);
        checkOutput("rst_mosi", {31'd0, mosi}, 32'd0);
        checkOutput("rst_busy", {31'd0, busy}, 32'd0);
        checkOutput("rst_rxValid", {31'd0, ifc.rx_valid_o}, 32'd0);
        checkOutput("rst_rxData", {24'd0, ifc.rx_data_o}, 32'd0);
        checkOutput("rst_txReady", {31'd0, ifc.tx_ready_o}, 32'd0);
        checkOutput("rst_cmdReady", {31'd0, ifc.cmd_ready_o}, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("idle_cmdReady", {31'd0, ifc.cmd_ready_o}, 32'd1);

        // Mode 0, clkdiv=1, one byte, loopback
        tbCpol = 1'b0;
        misoLoop = 1'b1;
        pushTx(8'hA5);
        pulseBase = pulseCnt; csbBase = csbLowCnt; popBase = txPopCnt; rxBase = rxCnt;
        applyStimulus(1'b0, 1'b0, 16'd1, 8'd0, 1'b0);
        waitIdle("t1", 300);
        checkOutput("t1_pulses", pulseCnt - pulseBase, 32'd8);
        checkOutput("t1_pulseSpan", pulseCyc[pulseBase + 7] - pulseCyc[pulseBase], 32'd28);
        checkOutput("t1_rxCount", rxCnt - rxBase, 32'd1);
        checkOutput("t1_rxData", {24'd0, rxArr[rxBase]}, 32'hA5);
        checkOutput("t1_csbLow", csbLowCnt - csbBase, 32'd38);
        checkOutput("t1_txPops", txPopCnt - popBase, 32'd1);
        checkOutput("t1_sckIdle", {31'd0, sck}, 32'd0);

        // Mode 3, three bytes, miso held low
        tbCpol = 1'b1;
        misoLoop = 1'b0;
        misoConst = 1'b0;
        pushTx(8'h01); pushTx(8'h80); pushTx(8'hFF);
        pulseBase = pulseCnt; popBase = txPopCnt; rxBase = rxCnt; riseBase = csbRiseCnt;
        applyStimulus(1'b1, 1'b1, 16'd2, 8'd2, 1'b0);
        waitIdle("t2", 800);
        checkOutput("t2_pulses", pulseCnt - pulseBase, 32'd24);
        checkOutput("t2_rxCount", rxCnt - rxBase, 32'd3);
        checkOutput("t2_rxData", {24'd0, rxArr[rxBase] | rxArr[rxBase + 1] | rxArr[rxBase + 2]}, 32'h00);
        checkOutput("t2_txPops", txPopCnt - popBase, 32'd3);
        checkOutput("t2_sckIdle", {31'd0, sck}, 32'd1);
        checkOutput("t2_csbRise", csbRiseCnt - riseBase, 32'd1);

        // Mode 1, two bytes, loopback
        tbCpol = 1'b0;
        misoLoop = 1'b1;
        pushTx(8'h3C); pushTx(8'hC3);
        pulseBase = pulseCnt; rxBase = rxCnt;
        applyStimulus(1'b0, 1'b1, 16'd1, 8'd1, 1'b0);
        waitIdle("t2b", 400);
        checkOutput("t2b_pulses", pulseCnt - pulseBase, 32'd16);
        checkOutput("t2b_rx0", {24'd0, rxArr[rxBase]}, 32'h3C);
        checkOutput("t2b_rx1", {24'd0, rxArr[rxBase + 1]}, 32'hC3);
        checkOutput("t2b_sckIdle", {31'd0, sck}, 32'd0);

        // Keep-cs chain: second command's cfg must be ignored
        pushTx(8'hA1); pushTx(8'hB2); pushTx(8'hC3);
        pulseBase = pulseCnt; rxBase = rxCnt; riseBase = csbRiseCnt;
        applyStimulus(1'b0, 1'b0, 16'd1, 8'd0, 1'b1);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(busy && ifc.cmd_ready_o) && n < 300);
        @(posedge clk);
        #1;
        checkOutput("t3_inKeep", {30'd0, busy, ifc.cmd_ready_o}, 32'd3);
        checkOutput("t3_firstPulses", pulseCnt - pulseBase, 32'd8);
        checkOutput("t3_noRiseYet", csbRiseCnt - riseBase, 32'd0);
        applyStimulus(1'b1, 1'b1, 16'd5, 8'd1, 1'b0);
        waitIdle("t3", 400);
        checkOutput("t3_pulses", pulseCnt - pulseBase, 32'd24);
        checkOutput("t3_rx0", {24'd0, rxArr[rxBase]}, 32'hA1);
        checkOutput("t3_rx1", {24'd0, rxArr[rxBase + 1]}, 32'hB2);
        checkOutput("t3_rx2", {24'd0, rxArr[rxBase + 2]}, 32'hC3);
        checkOutput("t3_csbRise", csbRiseCnt - riseBase, 32'd1);
        checkOutput("t3_lastSpan", pulseCyc[pulseBase + 23] - pulseCyc[pulseBase + 16], 32'd28);
        checkOutput("t3_sckIdle", {31'd0, sck}, 32'd0);

        // Rx backpressure: second byte must wait for the first to be taken
        ifc.rx_ready_i = 1'b0;
        pushTx(8'h5A); pushTx(8'h96);
        pulseBase = pulseCnt; popBase = txPopCnt; rxBase = rxCnt;
        applyStimulus(1'b0, 1'b0, 16'd1, 8'd1, 1'b0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!((pulseCnt - pulseBase) == 8 && ifc.rx_valid_o) && n < 300);
        repeat (30) @(negedge clk);
        @(posedge clk);
        #1;
        checkOutput("t4_stalledPulses", pulseCnt - pulseBase, 32'd8);
        checkOutput("t4_rxHeld", {31'd0, ifc.rx_valid_o}, 32'd1);
        checkOutput("t4_rxHeldData", {24'd0, ifc.rx_data_o}, 32'h5A);
        checkOutput("t4_stalledPops", txPopCnt - popBase, 32'd1);
        ifc.rx_ready_i = 1'b1;
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1;
        checkOutput("t4_resumedPops", txPopCnt - popBase, 32'd2);
        waitIdle("t4", 300);
        checkOutput("t4_pulses", pulseCnt - pulseBase, 32'd16);
        checkOutput("t4_rx0", {24'd0, rxArr[rxBase]}, 32'h5A);
        checkOutput("t4_rx1", {24'd0, rxArr[rxBase + 1]}, 32'h96);

        // Reset in the middle of a byte
        pushTx(8'h77);
        pulseBase = pulseCnt; rxBase = rxCnt;
        applyStimulus(1'b0, 1'b0, 16'd1, 8'd0, 1'b0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((pulseCnt - pulseBase) < 4 && n < 300);
        @(posedge clk);
        #1;
        rst = 1'b1;
        checkOutput("t5_cmdReadyInReset", {31'd0, ifc.cmd_ready_o}, 32'd0);
        @(posedge clk);
        #1;
        checkOutput("t5_csb", {31'd0, csb}, 32'd1);
        checkOutput("t5_sck", {31'd0, sck}, 32'd0);
        checkOutput("t5_busy", {31'd0, busy}, 32'd0);
        checkOutput("t5_rxValid", {31'd0, ifc.rx_valid_o}, 32'd0);
        checkOutput("t5_mosi", {31'd0, mosi}, 32'd0);
        rst = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        checkOutput("t5_noRx", rxCnt - rxBase, 32'd0);
        checkOutput("t5_stillIdle", {30'd0, busy, csb}, 32'd1);

        // clkdiv=0, 256 bytes
        tbCpol = 1'b0;
        misoLoop = 1'b1;
        for (int i = 0; i < 256; i++) pushTx(8'(i * 7 + 3));
        pulseBase = pulseCnt; popBase = txPopCnt; rxBase = rxCnt;
        applyStimulus(1'b0, 1'b0, 16'd0, 8'd255, 1'b0);
        waitIdle("t6", 9000);
        checkOutput("t6_pulses", pulseCnt - pulseBase, 32'd2048);
        checkOutput("t6_pulseSpan", pulseCyc[pulseBase + 7] - pulseCyc[pulseBase], 32'd14);
        checkOutput("t6_rxCount", rxCnt - rxBase, 32'd256);
        checkOutput("t6_txPops", txPopCnt - popBase, 32'd256);
        rxErrs = 0;
        for (int i = 0; i < 256; i++) begin
            if (rxArr[rxBase + i] !== 8'(i * 7 + 3)) rxErrs++;
        end
        checkOutput("t6_rxData", rxErrs, 32'd0);

        $display("[TB] %0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
